// File: rtl/axis_out_framer_pkg.sv
// Shared constants and the framer state type for the M_AXIS output stage.
package axis_out_framer_pkg;
    localparam int DW  = 32;      // fp32 words
    localparam int CW  = 12;      // beat counter width (ds)
    localparam int FW  = 8;       // frame counter width
    localparam int SW  = DW / 8;  // strobe width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } framer_state_e;
endpackage

// File: rtl/axis_out_framer_if.sv
// AXI4-Stream bundle for the framer output port.
interface axis_out_framer_if import axis_out_framer_pkg::*; #(parameter int W = DW);
    logic           tvalid;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic           tready;

    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_out_framer_skid_buf.sv
// Two-entry skid buffer (main + skid) with a registered upstream ready and flush.
module axis_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         accept_en,  // upstream may be accepted next cycle
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic         main_v, skid_v, main_v_n, skid_v_n;
    logic [W-1:0] main_d, skid_d, main_d_n, skid_d_n;
    logic         in_fire, out_fire;

    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = main_v & out_ready;
        main_v_n = main_v;
        main_d_n = main_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (skid_v) begin
            // skid only moves forward; a new word can land only if ready was high
            if (out_fire) begin
                main_d_n = skid_d;
                skid_v_n = in_fire;
                if (in_fire) skid_d_n = in_data;
            end
        end else if (main_v) begin
            if (out_fire) begin
                main_v_n = in_fire;
                if (in_fire) main_d_n = in_data;
            end else if (in_fire) begin
                skid_v_n = 1'b1;
                skid_d_n = in_data;
            end
        end else if (in_fire) begin
            main_v_n = 1'b1;
            main_d_n = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_d   <= '0;
            skid_d   <= '0;
            in_ready <= 1'b0;
        end else if (flush) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_d   <= '0;
            skid_d   <= '0;
            in_ready <= 1'b0;
        end else begin
            main_v   <= main_v_n;
            skid_v   <= skid_v_n;
            main_d   <= main_d_n;
            skid_d   <= skid_d_n;
            in_ready <= ~skid_v_n & accept_en;
        end
    end

    assign out_valid = main_v;
    assign out_data  = main_d;
endmodule

// File: rtl/axis_out_framer.sv
// Output framer: arms on run rising, streams len*nf words to M_AXIS with TLAST per frame,
// pulses done once the final beat has been accepted downstream.
module axis_out_framer import axis_out_framer_pkg::*; (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    input  logic                  run,
    input  logic [CW-1:0]         frame_len,
    input  logic [FW-1:0]         n_frames,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    axis_out_framer_if.master     m_axis,
    output logic                  done
);
    framer_state_e state;
    logic          run_q;
    logic [CW-1:0] len_r, in_beat, beat_cnt;
    logic [FW-1:0] nf_r, in_frame, frame_cnt;
    logic          in_all;

    logic          run_rise, in_fire, out_fire;
    logic          in_last, in_final, out_last_beat, out_final;
    logic          stay_active, accept_en;
    logic          buf_valid;
    logic [DW:0]   buf_data;

    // cfg-1 in CW/FW bits makes a zero config mean the full 2**width range
    always_comb begin
        run_rise      = run & ~run_q;
        in_fire       = in_valid & in_ready;
        out_fire      = buf_valid & m_axis.tready;
        in_last       = (in_beat == len_r - CW'(1));
        in_final      = in_last & (in_frame == nf_r - FW'(1));
        out_last_beat = (beat_cnt == len_r - CW'(1));
        out_final     = out_last_beat & (frame_cnt == nf_r - FW'(1));
        stay_active   = run & (((state == ST_ACTIVE) & ~(out_fire & out_final)) |
                               ((state == ST_IDLE) & run_rise));
        // arming clears the input count, so a stale in_all from the last run is ignored
        if (state == ST_IDLE)
            accept_en = stay_active;
        else
            accept_en = stay_active & ~(in_all | (in_fire & in_final));
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state     <= ST_IDLE;
            run_q     <= 1'b0;
            len_r     <= '0;
            nf_r      <= '0;
            in_beat   <= '0;
            in_frame  <= '0;
            in_all    <= 1'b0;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
        end else begin
            run_q <= run;
            done  <= 1'b0;
            if (!run) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_rise) begin
                            len_r     <= frame_len;
                            nf_r      <= n_frames;
                            in_beat   <= '0;
                            in_frame  <= '0;
                            in_all    <= 1'b0;
                            beat_cnt  <= '0;
                            frame_cnt <= '0;
                            state     <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (in_fire) begin
                            if (in_last) begin
                                in_beat  <= '0;
                                in_frame <= in_frame + FW'(1);
                            end else begin
                                in_beat  <= in_beat + CW'(1);
                            end
                            if (in_final) in_all <= 1'b1;
                        end
                        if (out_fire) begin
                            if (out_last_beat) begin
                                beat_cnt  <= '0;
                                frame_cnt <= frame_cnt + FW'(1);
                            end else begin
                                beat_cnt  <= beat_cnt + CW'(1);
                            end
                            if (out_final) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // TLAST travels with its word so it stays correct through stalls
    axis_skid_buf #(.W(DW + 1)) u_skid (
        .clk       (AXIS_ACLK),
        .rst_n     (AXIS_ARESETN),
        .flush     (~run),
        .accept_en (accept_en),
        .in_valid  (in_valid),
        .in_data   ({in_last, in_data}),
        .in_ready  (in_ready),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_ready (m_axis.tready)
    );

    assign m_axis.tvalid = buf_valid;
    assign m_axis.tdata  = buf_data[DW-1:0];
    assign m_axis.tlast  = buf_data[DW];
    assign m_axis.tstrb  = {SW{buf_valid}};
endmodule

// File: tb/tb_axis_out_framer.sv
// Directed bench for axis_out_framer: framing, stalls, abort, max length, async reset.
module tb_axis_out_framer;
    import axis_out_framer_pkg::*;

    logic          AXIS_ACLK = 1'b0;
    logic          AXIS_ARESETN;
    logic          run;
    logic [CW-1:0] frame_len;
    logic [FW-1:0] n_frames;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          done;

    axis_out_framer_if #(.W(DW)) m_axis ();

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    axis_out_framer dut (
        .AXIS_ACLK    (AXIS_ACLK),
        .AXIS_ARESETN (AXIS_ARESETN),
        .run          (run),
        .frame_len    (frame_len),
        .n_frames     (n_frames),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .m_axis       (m_axis),
        .done         (done)
    );

    // upstream source: counting words from src_base
    logic          src_en, src_clr;
    int            src_idx = 0;
    int            src_n;
    logic [DW-1:0] src_base;
    assign in_valid = src_en && (src_idx < src_n);
    assign in_data  = src_base + 32'(src_idx);
    always @(posedge AXIS_ACLK)
        if (src_clr) src_idx <= 0;
        else if (in_valid && in_ready) src_idx <= src_idx + 1;

    logic tr_val, tr_mode;
    logic tr_tog = 1'b0;
    always @(posedge AXIS_ACLK) tr_tog <= ~tr_tog;
    assign m_axis.tready = tr_mode ? tr_tog : tr_val;

    // output monitor: beat log, done timing, stall stability, buffer occupancy
    logic [DW-1:0] beat_q[$];
    logic          last_q[$];
    int            cyc_q[$];
    int            cyc = 0, done_cnt = 0, done_cyc = 0, occ = 0, occ_err = 0, stab_err = 0;
    logic          stall_q = 1'b0, stall_l = 1'b0;
    logic [DW-1:0] stall_d = '0;
    always @(posedge AXIS_ACLK) begin
        cyc <= cyc + 1;
        if (!AXIS_ARESETN) begin
            occ     <= 0;
            stall_q <= 1'b0;
        end else begin
            if (m_axis.tvalid && m_axis.tready) begin
                beat_q.push_back(m_axis.tdata);
                last_q.push_back(m_axis.tlast);
                cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (stall_q && run && (!m_axis.tvalid || m_axis.tdata != stall_d || m_axis.tlast != stall_l))
                stab_err <= stab_err + 1;
            stall_q <= m_axis.tvalid && !m_axis.tready;
            stall_d <= m_axis.tdata;
            stall_l <= m_axis.tlast;
            if (occ == 2 && in_ready) occ_err <= occ_err + 1;
            if (!run) occ <= 0;
            else occ <= occ + int'(in_valid && in_ready) - int'(m_axis.tvalid && m_axis.tready);
        end
    end

    int checks = 0, passed = 0, fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge AXIS_ACLK);
        #1;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (beat_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(beat_q.size() >= target), 64'd1);
    endtask

    task automatic start(input logic [CW-1:0] len, input logic [FW-1:0] nf,
                         input logic [DW-1:0] base, input int n);
        src_en  = 1'b0;
        src_clr = 1'b1;
        tick();
        src_clr   = 1'b0;
        frame_len = len;
        n_frames  = nf;
        src_base  = base;
        src_n     = n;
        src_en    = 1'b1;
        run       = 1'b1;
    endtask

    // counts beats from b0 whose data/last differ from base+i / last-every-len
    function automatic int bad_beats(input int b0, input int n, input logic [DW-1:0] base, input int len);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (beat_q[b0+i] !== base + 32'(i) || last_q[b0+i] !== ((i % len) == len - 1)) bad++;
        return bad;
    endfunction

    initial begin
        int b0, d0, nb, nl;
        AXIS_ARESETN = 1'b0;
        run = 1'b0; frame_len = '0; n_frames = '0;
        src_en = 1'b0; src_clr = 1'b1; src_base = '0; src_n = 0;
        tr_val = 1'b1; tr_mode = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_tdata", m_axis.tdata, 0);
        check("rst_tstrb", m_axis.tstrb, 0);
        check("rst_tlast", m_axis.tlast, 0);
        check("rst_done", done, 0);
        AXIS_ARESETN = 1'b1;
        src_clr = 1'b0;
        tick();

        // 1: len=4 nf=2, full rate
        b0 = beat_q.size(); d0 = done_cnt;
        start(12'd4, 8'd2, 32'h3F80_0000, 8);
        wait_done(d0, 100, "t1_done");
        check("t1_count", 64'(beat_q.size() - b0), 64'd8);
        if (beat_q.size() >= b0 + 8) begin
            check("t1_order_last", 64'(bad_beats(b0, 8, 32'h3F80_0000, 4)), 64'd0);
            check("t1_span", 64'(cyc_q[b0+7] - cyc_q[b0]), 64'd7);
            check("t1_done_lat", 64'(done_cyc - cyc_q[b0+7]), 64'd1);
        end
        tick();
        check("t1_done_quiet", {in_ready, m_axis.tvalid, done}, 0);
        run = 1'b0;
        repeat (2) tick();

        // 2: len=3 nf=1, TREADY toggling
        b0 = beat_q.size(); d0 = done_cnt;
        tr_mode = 1'b1;
        start(12'd3, 8'd1, 32'h0000_0100, 3);
        wait_done(d0, 100, "t2_done");
        check("t2_count", 64'(beat_q.size() - b0), 64'd3);
        if (beat_q.size() >= b0 + 3)
            check("t2_order_last", 64'(bad_beats(b0, 3, 32'h0000_0100, 3)), 64'd0);
        check("t2_stable", 64'(stab_err), 64'd0);
        check("t2_skid_ready", 64'(occ_err), 64'd0);
        run = 1'b0; tr_mode = 1'b0;
        repeat (2) tick();

        // 3: 10-cycle stall mid-frame
        b0 = beat_q.size(); d0 = done_cnt;
        start(12'd8, 8'd1, 32'h0000_0200, 8);
        wait_beats(b0 + 3, 50, "t3_first_beats");
        tr_val = 1'b0;
        nb = beat_q.size();
        repeat (10) tick();
        check("t3_stall_ready", in_ready, 0);
        check("t3_stall_valid", m_axis.tvalid, 1);
        check("t3_stall_occ", 64'(occ), 64'd2);
        check("t3_stall_nobeat", 64'(beat_q.size() - nb), 64'd0);
        tr_val = 1'b1;
        wait_done(d0, 100, "t3_done");
        check("t3_count", 64'(beat_q.size() - b0), 64'd8);
        if (beat_q.size() >= b0 + 8)
            check("t3_order_last", 64'(bad_beats(b0, 8, 32'h0000_0200, 8)), 64'd0);
        check("t3_stable", 64'(stab_err), 64'd0);
        check("t3_skid_ready", 64'(occ_err), 64'd0);
        run = 1'b0;
        repeat (2) tick();

        // 4: len=0 encodes 4096
        b0 = beat_q.size(); d0 = done_cnt;
        start(12'd0, 8'd1, 32'h0000_1000, 4096);
        wait_done(d0, 5000, "t4_done");
        check("t4_count", 64'(beat_q.size() - b0), 64'd4096);
        if (beat_q.size() >= b0 + 4096) begin
            nl = 0;
            for (int i = 0; i < 4096; i++) if (last_q[b0+i]) nl++;
            check("t4_last_count", 64'(nl), 64'd1);
            check("t4_last_pos", last_q[b0+4095], 1);
            check("t4_order_last", 64'(bad_beats(b0, 4096, 32'h0000_1000, 4096)), 64'd0);
        end
        run = 1'b0;
        repeat (2) tick();

        // 5: abort after 5 of 8 beats, then re-arm
        b0 = beat_q.size();
        start(12'd4, 8'd2, 32'h0000_0300, 8);
        wait_beats(b0 + 5, 50, "t5_five_beats");
        run = 1'b0;
        d0 = done_cnt;
        @(posedge AXIS_ACLK);
        @(negedge AXIS_ACLK);
        check("t5_abort_valid", m_axis.tvalid, 0);
        repeat (4) tick();
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_abort_ready", in_ready, 0);
        b0 = beat_q.size(); d0 = done_cnt;
        start(12'd2, 8'd1, 32'h0000_00A0, 2);
        wait_done(d0, 50, "t5_rearm_done");
        check("t5_rearm_count", 64'(beat_q.size() - b0), 64'd2);
        if (beat_q.size() >= b0 + 2)
            check("t5_rearm_order_last", 64'(bad_beats(b0, 2, 32'h0000_00A0, 2)), 64'd0);
        run = 1'b0;
        repeat (2) tick();

        // 6: async reset mid-stream, then a len=1 single-beat run
        b0 = beat_q.size();
        start(12'd8, 8'd1, 32'h0000_0400, 8);
        wait_beats(b0 + 3, 50, "t6_stream");
        #2;
        AXIS_ARESETN = 1'b0;
        #1;
        check("t6_async_valid", m_axis.tvalid, 0);
        check("t6_async_data", {m_axis.tdata, m_axis.tstrb, m_axis.tlast}, 0);
        check("t6_async_ready", {in_ready, done}, 0);
        run = 1'b0; src_en = 1'b0;
        repeat (2) tick();
        AXIS_ARESETN = 1'b1;
        repeat (3) tick();
        check("t6_idle_after", {in_ready, m_axis.tvalid}, 0);
        b0 = beat_q.size(); d0 = done_cnt;
        start(12'd1, 8'd1, 32'h0000_0055, 1);
        wait_done(d0, 50, "t6_len1_done");
        check("t6_len1_count", 64'(beat_q.size() - b0), 64'd1);
        if (beat_q.size() >= b0 + 1)
            check("t6_len1_beat", {beat_q[b0], last_q[b0]}, {32'h0000_0055, 1'b1});
        run = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
